// File: rtl/hilo_pkg.sv
// hilo_pkg: op encodings, FSM state type and multiply-latency legalisation for hilo_muldiv_unit
package hilo_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  function automatic int legal_mul_lat(input int l);
    return (l < 1) ? 1 : l;
  endfunction
endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one restoring-division iteration (shift in a dividend bit, trial subtract, restore on borrow)
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, trial;
  // a borrow out of the trial subtraction means the divisor did not fit this step
  always_comb begin
    shifted = {rem, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle mul/div engine owning HI/LO; define HILO_MADD_EN to enable MADD/MSUB
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int LAT = legal_mul_lat(MUL_LAT);
  localparam int CW  = $clog2(WIDTH + LAT + 1);
  state_t             state, nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, ext_a, ext_b, mul_res;
  logic [WIDTH-1:0]   rem, quo, dvs, abs_a, abs_b, rem_nxt;
  logic [2:0]         mul_op;
  logic               q_bit, neg_q, neg_r, sg, accept, is_mul, is_div, div_op;

  assign accept = start & ~flush & (state == IDLE);
  assign sg     = (op == OP_MULT) | (op == OP_DIV) | (op == OP_MADD) | (op == OP_MSUB);
  assign div_op = (op == OP_DIV) | (op == OP_DIVU);
  assign is_div = div_op & (src_b != '0);
`ifdef HILO_MADD_EN
  assign is_mul = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_MADD) | (op == OP_MSUB);
`else
  assign is_mul = (op == OP_MULT) | (op == OP_MULTU);
`endif
  assign ext_a   = {{WIDTH{sg & src_a[WIDTH-1]}}, src_a};
  assign ext_b   = {{WIDTH{sg & src_b[WIDTH-1]}}, src_b};
  assign abs_a   = (sg & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b   = (sg & src_b[WIDTH-1]) ? -src_b : src_b;
  assign mul_res = (mul_op == OP_MADD) ? {hi, lo} + prod : (mul_op == OP_MSUB) ? {hi, lo} - prod : prod;
  assign busy    = state != IDLE;

  hilo_div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .bit_in (quo[WIDTH-1]),
    .divisor(dvs),
    .rem_nxt(rem_nxt),
    .q_bit  (q_bit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state: countdowns finish MUL/DIV, FIX always completes, flush aborts anything in flight
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !accept ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE;
      MUL:     nxt = (cnt == '0) ? IDLE : MUL;
      DIV:     nxt = (cnt == '0) ? FIX : DIV;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  // datapath: latch operands on accept, iterate, and commit HI/LO with a Done pulse unless flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prod        <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      mul_op      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          prod   <= ext_a * ext_b;
          mul_op <= op;
          cnt    <= CW'(LAT - 1);
        end else if (is_div) begin
          rem   <= '0;
          quo   <= abs_a;
          dvs   <= abs_b;
          neg_q <= sg & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_r <= sg & src_a[WIDTH-1];
          cnt   <= CW'(WIDTH - 1);
        end else begin
          done        <= 1'b1;
          div_by_zero <= div_op;
          hi          <= (op == OP_MTHI || div_op) ? src_a : hi;
          lo          <= div_op ? '1 : (op == OP_MTLO) ? src_a : lo;
        end
      end else if (state == MUL) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0 && !flush) begin
          {hi, lo} <= mul_res;
          done     <= 1'b1;
        end
      end else if (state == DIV) begin
        rem <= rem_nxt;
        quo <= {quo[WIDTH-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end else if (state == FIX && !flush) begin
        lo   <= neg_q ? -quo : quo;
        hi   <= neg_r ? -rem : rem;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed scoreboard bench for hilo_muldiv_unit (WIDTH=32, MUL_LAT=3)
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int   cyc = 0, errors = 0, checks = 0;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) chk("unexpected_done", done, 1'b0);
      else begin
        e_mon = q.pop_front();
        chk("done_cycle", cyc, e_mon.cyc);
        chk("hi", hi, e_mon.hi);
        chk("lo", lo, e_mon.lo);
        chk("dbz", div_by_zero, e_mon.dbz);
        chk("busy_with_done", busy, 1'b0);
      end
    end
    if (rst_n && div_by_zero && !done) chk("dbz_without_done", div_by_zero, 1'b0);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input int k);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("issue_wait_idle", busy, 1'b0);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1;
    if (push) q.push_back('{eh, el, ed, cyc + 1 + k});
    @(posedge clk);
    #1 start = 0;
    chk("busy_after_accept", busy, k > 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk);
    #1 rst_n = 1;
    issue(OP_MULT,  32'hFFFFFFFD, 32'd7,        1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 3);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2,        1, 32'h00000001, 32'hFFFFFFFE, 0, 3);
    issue(OP_DIVU,  32'd100,      32'd7,        1, 32'd2,        32'd14,       0, 33);
    issue(OP_DIV,   32'hFFFFFF9C, 32'd7,        1, 32'hFFFFFFFE, 32'hFFFFFFF2, 0, 33);
    issue(OP_DIV,   32'd100,      32'hFFFFFFF9, 1, 32'd2,        32'hFFFFFFF2, 0, 33);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'd0,        32'h80000000, 0, 33);
    issue(OP_DIVU,  32'd7,        32'd100,      1, 32'd7,        32'd0,        0, 33);
    issue(OP_DIV,   32'd5,        32'd0,        1, 32'd5,        32'hFFFFFFFF, 1, 0);
    issue(OP_MTHI,  32'hDEADBEEF, 32'd0,        1, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
    issue(OP_MTLO,  32'd1,        32'd0,        1, 32'hDEADBEEF, 32'd1,        0, 0);
    wait_idle();
    issue(OP_DIVU, 32'd1000, 32'd3, 0, 0, 0, 0, 33);
    repeat (8) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("busy_after_flush", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi_kept", hi, 32'hDEADBEEF);
    chk("flush_lo_kept", lo, 32'd1);
    issue(OP_MULTU, 32'd5, 32'd5, 0, 0, 0, 0, 3);
    repeat (2) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("busy_after_late_flush", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("late_flush_lo_kept", lo, 32'd1);
    op    = OP_MTHI;
    src_a = 32'h55;
    start = 1;
    flush = 1;
    @(posedge clk);
    #1 start = 0;
    flush = 0;
    chk("busy_start_flush", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("start_flush_hi_kept", hi, 32'hDEADBEEF);
    issue(OP_MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 3);
    op    = OP_MTHI;
    src_a = 32'h77;
    start = 1;
    repeat (2) @(posedge clk);
    #1 start = 0;
    wait_idle();
    chk("ignored_hi", hi, 32'd0);
    chk("ignored_lo", lo, 32'd6);
`ifdef HILO_MADD_EN
    issue(OP_MTHI, 32'd0,  32'd0,        1, 32'd0, 32'd6,  0, 0);
    issue(OP_MTLO, 32'd10, 32'd0,        1, 32'd0, 32'd10, 0, 0);
    issue(OP_MADD, 32'd3,  32'd4,        1, 32'd0, 32'd22, 0, 3);
    issue(OP_MSUB, 32'd2,  32'hFFFFFFFD, 1, 32'd0, 32'd28, 0, 3);
`else
    issue(OP_MADD, 32'd3, 32'd4, 1, 32'd0, 32'd6, 0, 0);
    issue(OP_MSUB, 32'd3, 32'd4, 1, 32'd0, 32'd6, 0, 0);
`endif
    issue(OP_MULT, 32'd9, 32'd9, 0, 0, 0, 0, 3);
    #2 rst_n = 0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #2 rst_n = 1;
    issue(OP_MTLO, 32'h1234, 32'd0, 1, 32'd0, 32'h1234, 0, 0);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
